// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the Y86-64 pipeline stages.
// Holds the status codes carried down the pipe, the reserved "no register"
// ID, instruction codes, architectural register IDs, and small helpers for
// interpreting the W-stage status field.
package y86_pkg;

    localparam int NREG = 15;

    // 64-bit machine word.
    typedef logic [63:0] word_t;

    // Status codes carried alongside every instruction.
    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Register ID meaning "no register".
    localparam logic [3:0] RNONE = 4'hF;

    // Instruction codes.
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Architectural register IDs.
    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RRSP = 4'h4;
    localparam logic [3:0] RRBP = 4'h5;
    localparam logic [3:0] RRSI = 4'h6;
    localparam logic [3:0] RRDI = 4'h7;
    localparam logic [3:0] RR8  = 4'h8;
    localparam logic [3:0] RR9  = 4'h9;
    localparam logic [3:0] RR10 = 4'hA;
    localparam logic [3:0] RR11 = 4'hB;
    localparam logic [3:0] RR12 = 4'hC;
    localparam logic [3:0] RR13 = 4'hD;
    localparam logic [3:0] RR14 = 4'hE;

    // Anything other than a bubble or a normal instruction stops the machine.
    function automatic logic isException(input logic [2:0] stat);
        return (stat != SBUB) && (stat != SAOK);
    endfunction

    // Codes 5-7 are not defined and are recorded as an invalid instruction.
    function automatic logic [2:0] normStat(input logic [2:0] stat);
        return (stat > SINS) ? SINS : stat;
    endfunction

endpackage

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: 15 x 64-bit architectural register file.
// Two synchronous write ports (E and M) and two combinational read ports.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (clears all)
//   wrEnE_i, dstE_i, valE_i    write port E
//   wrEnM_i, dstM_i, valM_i    write port M (wins when both hit one register)
//   srcA_i / rvalA_o           read port A (RNONE reads as zero)
//   srcB_i / rvalB_o           read port B (RNONE reads as zero)
module regfile_2w2r
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrEnE_i,
    input  logic [3:0]  dstE_i,
    input  logic [63:0] valE_i,
    input  logic        wrEnM_i,
    input  logic [3:0]  dstM_i,
    input  logic [63:0] valM_i,
    input  logic [3:0]  srcA_i,
    input  logic [3:0]  srcB_i,
    output logic [63:0] rvalA_o,
    output logic [63:0] rvalB_o
);

    logic [63:0] regsQ [NREG];

    // Port M is evaluated after port E so its value lands when both target
    // the same register (popq %rsp needs the loaded value, not the bumped SP).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regsQ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wrEnE_i && (dstE_i == 4'(i))) begin
                    regsQ[i] <= valE_i;
                end
                if (wrEnM_i && (dstM_i == 4'(i))) begin
                    regsQ[i] <= valM_i;
                end
            end
        end
    end

    // Reads come straight from the array; a write in this cycle is not
    // bypassed, decode forwards from W itself.
    assign rvalA_o = (srcA_i == RNONE) ? '0 : regsQ[srcA_i];
    assign rvalB_o = (srcB_i == RNONE) ? '0 : regsQ[srcB_i];

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 write-back stage plus architectural registers.
// Commits the W-stage bundle into the register file, tracks the sticky
// processor status and counts retired instructions.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   W_stat, W_icode         status and icode of the W-stage instruction
//   W_valE/W_dstE           ALU result and its destination (RNONE = none)
//   W_valM/W_dstM           memory data and its destination (RNONE = none)
//   d_srcA/d_rvalA          decode read port A
//   d_srcB/d_rvalB          decode read port B
//   cpu_stat, halted        architectural status, halted once not AOK
//   retired                 retired non-nop instruction count
module writeback_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [63:0] retired
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;

    logic        stateQ, stateD;
    logic [2:0]  cpuStatQ, cpuStatD;
    logic [63:0] retiredQ, retiredD;
    logic        commit;

    // Only a normal instruction reaching W while still running may touch
    // architectural state; once halted, everything is frozen until reset.
    always_comb begin
        commit   = (W_stat == SAOK) && (stateQ == STATE_RUN);
        stateD   = stateQ;
        cpuStatD = cpuStatQ;
        retiredD = retiredQ;
        if ((stateQ == STATE_RUN) && isException(W_stat)) begin
            stateD   = STATE_HALT;
            cpuStatD = normStat(W_stat);
        end
        if (commit && (W_icode != INOP)) begin
            retiredD = retiredQ + 64'd1;
        end
    end

    // Status FSM and retire counter; the counter wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= STATE_RUN;
            cpuStatQ <= SAOK;
            retiredQ <= '0;
        end else begin
            stateQ   <= stateD;
            cpuStatQ <= cpuStatD;
            retiredQ <= retiredD;
        end
    end

    regfile_2w2r u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrEnE_i (commit && (W_dstE != RNONE)),
        .dstE_i  (W_dstE),
        .valE_i  (W_valE),
        .wrEnM_i (commit && (W_dstM != RNONE)),
        .dstM_i  (W_dstM),
        .valM_i  (W_valM),
        .srcA_i  (d_srcA),
        .srcB_i  (d_srcB),
        .rvalA_o (d_rvalA),
        .rvalB_o (d_rvalB)
    );

    assign cpu_stat = cpuStatQ;
    assign halted   = (stateQ == STATE_HALT);
    assign retired  = retiredQ;

endmodule
